mux_pam_tdm: RTL and testbench

//  Time-division successor to the combinational PAM mux. Scans DEPTH input channels,

---
 rtl/mux_pam_pkg.sv | 15 +
 rtl/pam_chan_next.sv | 39 +++
 rtl/mux_pam_tdm.sv | 159 +++++++++++++++
 tb/tb_mux_pam_tdm.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pam_pkg.sv
// Shared types and constants for the time-division PAM channel mux.
package mux_pam_pkg;

    // Scan FSM: wait for enable, dwell on a channel, present the captured sample.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DWELL   = 2'd1,
        PRESENT = 2'd2
    } pam_tdm_state_t;

    // Values of the mode input.
    localparam logic MODE_AUTO   = 1'b0;
    localparam logic MODE_MANUAL = 1'b1;

endpackage

// File: rtl/pam_chan_next.sv
// Rotate-priority channel finder: returns the first set mask bit at (inclusive) or
// strictly after (exclusive) ptr_i, wrapping from DEPTH-1 back to 0. In exclusive mode
// ptr_i itself is the last candidate, so a single-bit mask reselects the same channel.
module pam_chan_next #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [DEPTH-1:0] mask_i,
    input  logic             incl_i,
    output logic [PTR_W-1:0] next_o,
    output logic             found_o
);

    logic [PTR_W-1:0] next_idx;
    logic             found;
    int unsigned      cand;

    // Walk DEPTH candidate positions starting at ptr (or ptr+1) and keep the first hit.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            cand = 32'(ptr_i) + k + (incl_i ? 32'd0 : 32'd1);
            if (cand >= DEPTH) begin
                cand = cand - DEPTH;
            end
            if (!found && mask_i[PTR_W'(cand)]) begin
                found    = 1'b1;
                next_idx = PTR_W'(cand);
            end
        end
    end

    assign next_o  = next_idx;
    assign found_o = found;

endmodule

// File: rtl/mux_pam_tdm.sv
// Time-division PAM mux: scans DEPTH channels (auto over a mask, or one manually chosen
// channel), dwells a programmable number of cycles on each, then registers one sample and
// offers it on a valid/ready handshake tagged with its channel index.
module mux_pam_tdm
    import mux_pam_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DWELL_W = 8,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   inputs [DEPTH],
    input  logic               enable,
    input  logic               mode,
    input  logic [PTR_W-1:0]   sel_man,
    input  logic [DEPTH-1:0]   ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   out,
    output logic [PTR_W-1:0]   out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_start
);

    pam_tdm_state_t     state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [PTR_W-1:0]   out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_start_q, frame_start_d;

    logic [PTR_W-1:0]   sel_man_clamped;
    logic [PTR_W-1:0]   nxt_ptr;
    logic               nxt_found;
    logic [PTR_W-1:0]   low_ptr;
    logic               low_found;
    logic               handshake;
    logic               search_incl;

    // Out-of-range manual selections fall back to channel 0.
    assign sel_man_clamped = (32'(sel_man) >= DEPTH) ? '0 : sel_man;
    assign handshake       = out_valid_q & out_ready;
    // From IDLE the current pointer may be reused; on advance it must move on.
    assign search_incl     = (state_q == IDLE);

    pam_chan_next #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_next (
        .ptr_i   (ptr_q),
        .mask_i  (ch_mask),
        .incl_i  (search_incl),
        .next_o  (nxt_ptr),
        .found_o (nxt_found)
    );

    // Lowest set mask bit marks the first channel of a frame.
    pam_chan_next #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_lowest (
        .ptr_i   ('0),
        .mask_i  (ch_mask),
        .incl_i  (1'b1),
        .next_o  (low_ptr),
        .found_o (low_found)
    );

    // Next-state logic for the scan FSM, dwell counter and output registers.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        out_d         = out_q;
        out_ch_d      = out_ch_q;
        out_valid_d   = out_valid_q;
        frame_start_d = frame_start_q;

        case (state_q)
            IDLE: begin
                if (enable && ((mode == MODE_MANUAL) || nxt_found)) begin
                    state_d = DWELL;
                    cnt_d   = dwell;
                    ptr_d   = (mode == MODE_MANUAL) ? sel_man_clamped : nxt_ptr;
                end
            end

            DWELL: begin
                if (!enable) begin
                    // Abort: the dwell in progress produces no sample.
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    out_d         = inputs[ptr_q];
                    out_ch_d      = ptr_q;
                    out_valid_d   = 1'b1;
                    frame_start_d = (mode == MODE_AUTO) && low_found && (low_ptr == ptr_q);
                    state_d       = PRESENT;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end

            PRESENT: begin
                if (handshake) begin
                    out_valid_d   = 1'b0;
                    frame_start_d = 1'b0;
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (mode == MODE_MANUAL) begin
                        ptr_d   = sel_man_clamped;
                        cnt_d   = dwell;
                        state_d = DWELL;
                    end else if (nxt_found) begin
                        ptr_d   = nxt_ptr;
                        cnt_d   = dwell;
                        state_d = DWELL;
                    end else begin
                        // Mask emptied while dwelling: nothing left to scan.
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            out_q         <= '0;
            out_ch_q      <= '0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            out_q         <= out_d;
            out_ch_q      <= out_ch_d;
            out_valid_q   <= out_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out         = out_q;
    assign out_ch      = out_ch_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_mux_pam_tdm.sv
// Self-checking bench for mux_pam_tdm: directed scenarios plus randomized auto scans,
// checked against a transaction-level model (channel order, sample data, timing gaps).
module tb_mux_pam_tdm;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int DWELL_W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   inputs [DEPTH];
    logic         enable = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   sel_man = '0;
    logic [7:0]   ch_mask = '0;
    logic [7:0]   dwell = '0;
    logic [7:0]   out;
    logic [2:0]   out_ch;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_pam_tdm #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inputs      (inputs),
        .enable      (enable),
        .mode        (mode),
        .sel_man     (sel_man),
        .ch_mask     (ch_mask),
        .dwell       (dwell),
        .out         (out),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_start (frame_start)
    );

    // Reference: first set mask bit at/after p (incl) or strictly after p, modulo DEPTH.
    function automatic int next_chan(input int p, input logic [7:0] m, input bit incl);
        for (int k = 0; k < DEPTH; k++) begin
            int c;
            c = (p + k + (incl ? 0 : 1)) % DEPTH;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_fs(input int ch, input logic [7:0] m);
        return (next_chan(0, m, 1'b1) == ch) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        out_ready = 1'b0;
        mode      = 1'b0;
        ch_mask   = '0;
        dwell     = '0;
        sel_man   = '0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < DEPTH; i++) inputs[i] = 8'($urandom);
    endtask

    // Waits (bounded) for the next sample and checks gap, channel, data and frame flag.
    task automatic wait_sample(input string name, input int e_ch, input int e_data,
                               input int e_fs, input int e_gap);
        int gap;
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!out_valid && gap < 300);
        n_tests++;
        if (out_valid !== 1'b1) begin
            $display("FAIL %s timeout: out_valid=%0b after %0d cycles, expected 1", name,
                     out_valid, gap);
            n_fail++;
            return;
        end
        n_tests++;
        if (gap != e_gap) begin
            $display("FAIL %s gap: got %0d expected %0d", name, gap, e_gap);
            n_fail++;
        end
        n_tests++;
        if (int'(out_ch) != e_ch) begin
            $display("FAIL %s out_ch: got %0d expected %0d", name, out_ch, e_ch);
            n_fail++;
        end
        n_tests++;
        if (out !== 8'(e_data)) begin
            $display("FAIL %s out: got %0h expected %0h", name, out, 8'(e_data));
            n_fail++;
        end
        if (e_fs >= 0) begin
            n_tests++;
            if (int'(frame_start) != e_fs) begin
                $display("FAIL %s frame_start: got %0b expected %0d", name, frame_start, e_fs);
                n_fail++;
            end
        end
    endtask

    // Holds ready low for n cycles; the presented sample must stay put.
    task automatic check_hold(input string name, input int n, input int e_ch, input int e_data);
        for (int i = 0; i < n; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || int'(out_ch) != e_ch || out !== 8'(e_data)) begin
                $display("FAIL %s hold[%0d]: valid=%0b ch=%0d out=%0h expected 1/%0d/%0h",
                         name, i, out_valid, out_ch, out, e_ch, 8'(e_data));
                n_fail++;
            end
        end
    endtask

    task automatic check_idle(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            $display("FAIL %s idle: out_valid high in %0d cycles, expected 0", name, seen);
            n_fail++;
        end
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (out !== 8'h00 || out_ch !== 3'd0 || out_valid !== 1'b0 || frame_start !== 1'b0) begin
            $display("FAIL %s: out=%0h ch=%0d valid=%0b fs=%0b expected all 0", name, out,
                     out_ch, out_valid, frame_start);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rand_inputs();
        do_reset();
        check_zero("reset_state");
        ch_mask   = 8'b0000_0001;
        dwell     = 8'd1;
        out_ready = 1'b0;
        enable    = 1'b1;
        wait_sample("reset_pre", 0, inputs[0], 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async");
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        check_idle("reset_after", 5);
    endtask

    task automatic test_auto_spec();
        int ch;
        do_reset();
        for (int i = 0; i < DEPTH; i++) inputs[i] = 8'(i * 16 + 1);
        ch_mask   = 8'b1010_0101;
        dwell     = 8'd3;
        out_ready = 1'b1;
        enable    = 1'b1;
        ch = next_chan(0, ch_mask, 1'b1);
        for (int s = 0; s < 6; s++) begin
            wait_sample("auto_spec", ch, inputs[ch], exp_fs(ch, ch_mask), 5);
            ch = next_chan(ch, ch_mask, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < DEPTH; i++) inputs[i] = 8'(i * 16 + 1);
        ch_mask   = 8'b1010_0101;
        dwell     = 8'd3;
        out_ready = 1'b1;
        enable    = 1'b1;
        wait_sample("bp_ch0", 0, inputs[0], 1, 5);
        tick();
        out_ready = 1'b0;
        wait_sample("bp_ch2", 2, inputs[2], 0, 4);
        check_hold("bp_ch2", 10, 2, inputs[2]);
        out_ready = 1'b1;
        wait_sample("bp_ch5", 5, inputs[5], 0, 5);
    endtask

    task automatic test_manual();
        do_reset();
        rand_inputs();
        mode      = 1'b1;
        ch_mask   = 8'b1111_1111;
        sel_man   = 3'd6;
        dwell     = 8'd0;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int s = 0; s < 3; s++) wait_sample("man_6", 6, inputs[6], 0, 2);
        sel_man = 3'd3;
        for (int s = 0; s < 3; s++) wait_sample("man_3", 3, inputs[3], 0, 2);
        for (int s = 0; s < 4; s++) begin
            int sel;
            sel = int'($urandom_range(0, DEPTH - 1));
            sel_man = 3'(sel);
            wait_sample("man_rand", sel, inputs[sel], 0, 2);
        end
    endtask

    task automatic test_enable_drop();
        int ch;
        do_reset();
        rand_inputs();
        ch_mask = 8'($urandom_range(1, 255));
        ch      = next_chan(0, ch_mask, 1'b1);
        dwell   = 8'd3;
        out_ready = 1'b1;
        enable  = 1'b1;
        tick();
        tick();
        tick();
        enable = 1'b0;
        check_idle("drop_dwell", 10);
        out_ready = 1'b0;
        enable    = 1'b1;
        wait_sample("drop_present", ch, inputs[ch], exp_fs(ch, ch_mask), 5);
        enable = 1'b0;
        check_hold("drop_present", 3, ch, inputs[ch]);
        out_ready = 1'b1;
        check_idle("drop_after_hs", 10);
    endtask

    task automatic test_single_mask();
        int d;
        do_reset();
        rand_inputs();
        d         = int'($urandom_range(0, 4));
        dwell     = 8'(d);
        ch_mask   = 8'b0001_0000;
        out_ready = 1'b1;
        enable    = 1'b1;
        for (int s = 0; s < 3; s++) wait_sample("single", 4, inputs[4], 1, d + 2);
        tick();
        ch_mask = 8'h00;
        wait_sample("mask_zero", 4, inputs[4], -1, d + 1);
        check_idle("mask_zero", 10);
    endtask

    task automatic test_auto_random();
        for (int r = 0; r < 4; r++) begin
            int ch;
            int d;
            do_reset();
            rand_inputs();
            d         = int'($urandom_range(0, 4));
            dwell     = 8'(d);
            ch_mask   = 8'($urandom_range(1, 255));
            out_ready = 1'b0;
            enable    = 1'b1;
            ch = next_chan(0, ch_mask, 1'b1);
            wait_sample("rand_first", ch, inputs[ch], exp_fs(ch, ch_mask), d + 2);
            for (int s = 0; s < 6; s++) begin
                check_hold("rand_stall", int'($urandom_range(0, 3)), ch, inputs[ch]);
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
                rand_inputs();
                ch = next_chan(ch, ch_mask, 1'b0);
                wait_sample("rand", ch, inputs[ch], exp_fs(ch, ch_mask), d + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) inputs[i] = '0;
        test_reset();
        test_auto_spec();
        test_backpressure();
        test_manual();
        test_enable_drop();
        test_single_mask();
        test_auto_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
